key_scan_ctrl: RTL



---
 rtl/key_scan_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/key_scan_ctrl.sv
// Keypad scan controller: sweeps a 4-to-16 decoder line by line, debounces a
// hit on the sense return, reports the line as a key code, then waits for release.
module key_scan_ctrl #(
  parameter int DWELL    = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_en,
  input  logic       sense,
  output logic [3:0] sel,
  output logic       sel_en,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held
);

  // state        | meaning
  // ST_IDLE      | parked, decoder disabled, sel=0
  // ST_SCAN      | sweeping lines, one dwell period each
  // ST_CONFIRM   | hit seen on sel, collecting consecutive hit samples
  // ST_OUTPUT    | key_code presented, waiting for key_ready
  // ST_WAIT_REL  | key reported, collecting consecutive release samples
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_CONFIRM,
    ST_OUTPUT,
    ST_WAIT_REL
  } state_t;

  localparam int DW = $clog2(DWELL) + 1;
  localparam int HW = $clog2(DEBOUNCE) + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [HW-1:0] HIT_FULL   = HW'(DEBOUNCE);

  state_t        state_q, state_d;
  logic [3:0]    sel_q, sel_d;
  logic [3:0]    code_q, code_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [HW-1:0] hit_q, hit_d;

  logic          dwell_end;
  logic [DW-1:0] dwell_nxt;
  logic [HW-1:0] hit_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      code_q  <= '0;
      dwell_q <= '0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      code_q  <= code_d;
      dwell_q <= dwell_d;
      hit_q   <= hit_d;
    end
  end

  assign dwell_end = (dwell_q == DWELL_LAST);
  assign dwell_nxt = dwell_end ? '0 : dwell_q + DW'(1);
  assign hit_inc   = hit_q + HW'(1);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    code_d  = code_q;
    dwell_d = dwell_q;
    hit_d   = hit_q;

    case (state_q)
      ST_IDLE: begin
        sel_d   = '0;
        dwell_d = '0;
        hit_d   = '0;
        if (scan_en) state_d = ST_SCAN;
      end

      ST_SCAN, ST_CONFIRM: begin
        if (!scan_en) begin
          // dropping scan_en discards any partial debounce
          state_d = ST_IDLE;
          sel_d   = '0;
          dwell_d = '0;
          hit_d   = '0;
        end else begin
          dwell_d = dwell_nxt;
          if (dwell_end) begin
            if (sense) begin
              hit_d = (state_q == ST_SCAN) ? HW'(1) : hit_inc;
              if (((state_q == ST_SCAN) ? HW'(1) : hit_inc) == HIT_FULL) begin
                state_d = ST_OUTPUT;
                code_d  = sel_q;
              end else begin
                state_d = ST_CONFIRM;
              end
            end else begin
              state_d = ST_SCAN;
              sel_d   = sel_q + 4'd1;
              hit_d   = '0;
            end
          end
        end
      end

      ST_OUTPUT: begin
        dwell_d = '0;
        if (key_ready) begin
          state_d = ST_WAIT_REL;
          hit_d   = '0;
        end
      end

      ST_WAIT_REL: begin
        // hit_q counts consecutive released samples here
        dwell_d = dwell_nxt;
        if (dwell_end) begin
          if (sense) begin
            hit_d = '0;
          end else if (hit_inc == HIT_FULL) begin
            hit_d   = '0;
            state_d = scan_en ? ST_SCAN : ST_IDLE;
            sel_d   = scan_en ? sel_q + 4'd1 : 4'd0;
          end else begin
            hit_d = hit_inc;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
        dwell_d = '0;
        hit_d   = '0;
      end
    endcase
  end

  assign sel       = sel_q;
  assign sel_en    = (state_q != ST_IDLE);
  assign key_code  = code_q;
  assign key_valid = (state_q == ST_OUTPUT);
  assign key_held  = (state_q == ST_WAIT_REL);

endmodule
